// File: rtl/ext_pkg.sv
// Shared constants for the sign/zero-extension arbiter slice.
// Covers the extender mode encodings, the requester identifiers and the default tag width.
package ext_pkg;

    localparam logic EXT_BYTE = 1'b0;
    localparam logic EXT_HALF = 1'b1;

    localparam logic SRC_ID  = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    localparam int EXT_TAG_W = 5;

endpackage

// File: rtl/ext_unit.sv
// Combinational 8/16 -> 32 bit sign/zero extender.
// The mode is selected at runtime by the granted request.
module ext_unit
    import ext_pkg::*;
(
    input  logic [15:0] d,
    input  logic        half,
    input  logic        sext,
    output logic [31:0] y
);

    function automatic logic [31:0] extend(input logic [15:0] src, input logic is_half,
                                           input logic is_signed);
        logic signed [15:0] h_s;
        logic signed [7:0]  b_s;
        logic [31:0]        r;
        h_s = src;
        b_s = src[7:0];
        if (is_half == EXT_HALF)
            r = is_signed ? 32'(h_s) : {16'h0000, src};
        else
            r = is_signed ? 32'(b_s) : {24'h000000, src[7:0]};
        return r;
    endfunction

    assign y = extend(d, half, sext);

endmodule

// File: rtl/ext_share_ctrl.sv
// Round-robin front end for the shared extension unit: arbitrates ID and MEM
// requests, extends the winner and holds the result in a one-entry output stage.
module ext_share_ctrl
    import ext_pkg::*;
#(
    parameter int TAG_W = EXT_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [15:0]      req0_data,
    input  logic             req0_half,
    input  logic             req0_sext,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [15:0]      req1_data,
    input  logic             req1_half,
    input  logic             req1_sext,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_src
);

    logic             last_grant;
    logic             can_load;
    logic             gnt_vld_p0;
    logic             gnt_sel_p0;
    logic             xfer_p0;
    logic [15:0]      data_p0;
    logic             half_p0;
    logic             sext_p0;
    logic [TAG_W-1:0] tag_p0;
    logic [31:0]      ext_p0;

    assign can_load = !rsp_valid || rsp_ready;

    // Stage p0: arbitration and operand select
    always_comb begin
        gnt_vld_p0 = req0_valid | req1_valid;
        gnt_sel_p0 = SRC_ID;
        if (req0_valid && req1_valid)
            gnt_sel_p0 = ~last_grant;
        else if (req1_valid)
            gnt_sel_p0 = SRC_MEM;
    end

    // Ready is held low while reset is asserted even though can_load is high then.
    assign xfer_p0    = rst_n & gnt_vld_p0 & can_load & !flush;
    assign req0_ready = xfer_p0 & (gnt_sel_p0 == SRC_ID);
    assign req1_ready = xfer_p0 & (gnt_sel_p0 == SRC_MEM);

    always_comb begin
        data_p0 = req0_data;
        half_p0 = req0_half;
        sext_p0 = req0_sext;
        tag_p0  = req0_tag;
        if (gnt_sel_p0 == SRC_MEM) begin
            data_p0 = req1_data;
            half_p0 = req1_half;
            sext_p0 = req1_sext;
            tag_p0  = req1_tag;
        end
    end

    ext_unit u_ext (
        .d    (data_p0),
        .half (half_p0),
        .sext (sext_p0),
        .y    (ext_p0)
    );

    // Stage p1: output register and grant history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_tag    <= '0;
            rsp_src    <= SRC_ID;
            last_grant <= SRC_MEM;
        end else if (flush) begin
            rsp_valid <= 1'b0;
        end else if (xfer_p0) begin
            rsp_valid  <= 1'b1;
            rsp_data   <= ext_p0;
            rsp_tag    <= tag_p0;
            rsp_src    <= gnt_sel_p0;
            last_grant <= gnt_sel_p0;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: doc/ext_share_ctrl.md
# ext_share_ctrl

Arbitrated, pipelined front end for the CPU's shared sign/zero-extension datapath. Two requesters compete for a single extension resource: the ID-stage immediate path (requester 0) and the MEM-stage load-byte/halfword path (requester 1). The block grants round-robin, configures the extender per request (8/16-bit source, sign/zero), and returns a registered 32-bit result with tag and source over a valid/ready handshake. Sits between decode/memory stages and the writeback/operand-forwarding logic.

## Interface
- TAG_W, 5, width of the destination-register tag carried with each request
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; drops held result, blocks grants this cycle
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (valid & ready)
- req0_data / req1_data  in  16  source operand; byte mode uses [7:0] only
- req0_half / req1_half  in  1  1 = 16-bit source, 0 = 8-bit source
- req0_sext / req1_sext  in  1  1 = sign-extend, 0 = zero-extend
- req0_tag / req1_tag  in  TAG_W  destination tag
- rsp_valid  out  1  result register holds a valid result
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  32  extended result
- rsp_tag  out  TAG_W  tag of the result
- rsp_src  out  1  0 = requester 0, 1 = requester 1

## Operation
- can_load = !rsp_valid | rsp_ready; the output register is a one-entry pipe stage.
- Grant: only one valid -> that one; both valid -> the requester not in last_grant; none -> no grant.
- reqN_ready = can_load & !flush & (grant == N). Ready is combinational from valid; requesters must not make valid depend on ready.
- last_grant updates only on an accepted transfer (valid & ready), never on a mere grant.
- Extension: half=1 -> {16{sext & d[15]}, d[15:0]}; half=0 -> {24{sext & d[7]}, d[7:0]}; d[15:8] ignored in byte mode.
- On transfer: rsp_data/tag/src load; rsp_valid <= 1. If rsp_valid & rsp_ready with no transfer, rsp_valid <= 0; data/tag/src hold their last value.
- flush: rsp_valid <= 0 next edge regardless of rsp_ready or pending grant; last_grant unchanged; the result presented in the flush cycle is not counted as delivered even if rsp_ready = 1.
- A request held valid while ready = 0 must keep data, half, sext, and tag stable.

## Timing
- Reset (async, immediate): rsp_valid = 0, rsp_data = 0, rsp_tag = 0, rsp_src = 0, last_grant = 1 (requester 0 wins the first contention). reqN_ready = 0 while rst_n = 0.
- Latency: request accepted at edge k -> rsp_valid = 1 with the result after edge k.
- Throughput: one result per cycle with rsp_ready held at 1; back-to-back contention alternates 0,1,0,1.
- Backpressure: rsp_valid & !rsp_ready -> both ready = 0; rsp_* stable until accepted.
- Simultaneous drain and load (rsp_valid & rsp_ready & transfer) -> the new result replaces the old in the same edge; no bubble.
- Reset asserted mid-transfer discards the held result; there is no replay.

## Structure
- Package ext_pkg: EXT_BYTE/EXT_HALF mode constants, SRC_ID = 0 / SRC_MEM = 1, default TAG_W.
- Sub-module ext_unit: purely combinational runtime-width (8/16 -> 32) sign/zero extender, instantiated once on the granted request's fields.
- Top holds the arbiter, last_grant flop, output register, and handshake logic.

## Test plan
- Reset release with req0 only: data=16'h8001, half=1, sext=1, tag=3 -> one cycle later rsp_data=32'hFFFF8001, rsp_tag=3, rsp_src=0.
- Byte modes: req1 data=16'h12F0, half=0, sext=1 -> 32'hFFFFFFF0; sext=0 -> 32'h000000F0 (upper byte 8'h12 ignored).
- Contention for 4 cycles with rsp_ready=1 -> grants 0,1,0,1; each result arrives one cycle after its ready pulse; no bubbles.
- Backpressure: rsp_valid=1, rsp_ready=0 for 3 cycles with both requesters valid -> both ready=0, rsp_* stable; on rsp_ready=1, new result loads the same edge.
- Flush with rsp_valid=1 and req0 valid -> rsp_valid=0 next cycle, req0_ready=0 in the flush cycle, last_grant unchanged, req0 accepted the following cycle.
- Async reset mid-stream -> rsp_valid drops immediately without a clock edge; after release requester 0 wins the first contention.
